// File: rtl/mastermind_pkg.sv
// Shared types and defaults for the Mastermind round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mastermind_pkg;

  typedef enum logic [1:0] {
    WAITING  = 2'd0,
    GUESSING = 2'd1,
    GRADING  = 2'd2,
    DONE     = 2'd3
  } round_state_t;

  localparam int DEFAULT_NUM_ROUNDS = 8;

endpackage

// File: rtl/mastermind_round_ctrl_if.sv
// Game-control bus between debounce logic, the round controller and the datapath.
// Latency: n/a (wires only).
// Backpressure: none; grader result is a single-cycle valid pulse.
interface mastermind_round_ctrl_if #(
  parameter int NUM_ROUNDS = mastermind_pkg::DEFAULT_NUM_ROUNDS
) ();
  localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

  logic               start_game;
  logic               grade_it;
  logic               grade_valid;
  logic               grade_match;
  logic               practice;
  logic               abort;
  logic               c_clear;
  logic               c_en;
  logic               f_load;
  logic               f_clear;
  logic [ROUND_W-1:0] round_cnt;
  logic               busy;
  logic               won;
  logic               lost;

  // Drives user/grader events and observes controller outputs.
  modport master (
    output start_game, grade_it, grade_valid, grade_match, practice, abort,
    input  c_clear, c_en, f_load, f_clear, round_cnt, busy, won, lost
  );

  // The round controller itself.
  modport slave (
    input  start_game, grade_it, grade_valid, grade_match, practice, abort,
    output c_clear, c_en, f_load, f_clear, round_cnt, busy, won, lost
  );
endinterface

// File: rtl/round_counter.sv
// Saturating guess counter with synchronous clear and enable.
// Latency: count updates on the edge after clr/en.
// Backpressure: none; saturates at all-ones instead of wrapping.
module round_counter #(
  parameter int ROUND_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] cnt
);

  logic [ROUND_W-1:0] cnt_q;
  logic [ROUND_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {ROUND_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Sequences a Mastermind game: start, guess entry, grading handshake, win/loss.
// Latency: strobes are Mealy (same cycle); state/round_cnt/won/lost update next edge.
// Backpressure: waits in GRADING indefinitely for the grader's valid pulse.
module mastermind_round_ctrl
  import mastermind_pkg::*;
#(
  parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
  localparam int ROUND_W   = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  mastermind_round_ctrl_if.slave bus
);

  if (NUM_ROUNDS < 1) begin : g_bad_num_rounds
    $error("mastermind_round_ctrl: NUM_ROUNDS must be >= 1");
  end

  localparam logic [1:0] S_WAITING  = 2'(WAITING);
  localparam logic [1:0] S_GUESSING = 2'(GUESSING);
  localparam logic [1:0] S_GRADING  = 2'(GRADING);
  localparam logic [1:0] S_DONE     = 2'(DONE);

  logic [1:0]         state_q, state_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;
  logic               practice_q, practice_d;
  logic               c_clear, c_en, f_load, f_clear;
  logic               cnt_clr;
  logic [ROUND_W-1:0] round_cnt;

  round_counter #(.ROUND_W(ROUND_W)) u_round_counter (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (c_en),
    .cnt   (round_cnt)
  );

  // Next-state and Mealy strobe decode; abort outranks every other event.
  always_comb begin
    state_d    = state_q;
    won_d      = won_q;
    lost_d     = lost_q;
    practice_d = practice_q;
    c_clear    = 1'b0;
    c_en       = 1'b0;
    f_load     = 1'b0;
    f_clear    = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      S_WAITING, S_DONE: begin
        if ((state_q == S_DONE) && bus.abort) begin
          state_d = S_WAITING;
          f_clear = 1'b1;
          won_d   = 1'b0;
          lost_d  = 1'b0;
          cnt_clr = 1'b1;
        end else if (bus.start_game) begin
          // New game: results and counter cleared, practice mode latched.
          state_d    = S_GUESSING;
          c_clear    = 1'b1;
          cnt_clr    = 1'b1;
          practice_d = bus.practice;
          won_d      = 1'b0;
          lost_d     = 1'b0;
        end
      end
      S_GUESSING: begin
        if (bus.abort) begin
          state_d = S_WAITING;
          f_clear = 1'b1;
          won_d   = 1'b0;
          lost_d  = 1'b0;
          cnt_clr = 1'b1;
        end else if (bus.grade_it) begin
          state_d = S_GRADING;
          c_en    = 1'b1;
          f_load  = 1'b1;
        end
      end
      S_GRADING: begin
        if (bus.abort) begin
          state_d = S_WAITING;
          f_clear = 1'b1;
          won_d   = 1'b0;
          lost_d  = 1'b0;
          cnt_clr = 1'b1;
        end else if (bus.grade_valid) begin
          if (bus.grade_match) begin
            state_d = S_DONE;
            won_d   = 1'b1;
            f_clear = 1'b1;
          end else if (!practice_q && (round_cnt == ROUND_W'(NUM_ROUNDS))) begin
            state_d = S_DONE;
            lost_d  = 1'b1;
            f_clear = 1'b1;
          end else begin
            state_d = S_GUESSING;
          end
        end
      end
      default: begin
        state_d = S_WAITING;
      end
    endcase
  end

  // State and sticky result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_WAITING;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
      practice_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
      practice_q <= practice_d;
    end
  end

  assign bus.c_clear   = c_clear;
  assign bus.c_en      = c_en;
  assign bus.f_load    = f_load;
  assign bus.f_clear   = f_clear;
  assign bus.round_cnt = round_cnt;
  assign bus.busy      = (state_q == S_GUESSING) || (state_q == S_GRADING);
  assign bus.won       = won_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Directed bench for mastermind_round_ctrl with NUM_ROUNDS=4.
// Expected strobes/registered outputs are queued per step and popped when checked.
// Inputs change 1 time unit after posedge; strobes sampled before the next edge.
module tb_mastermind_round_ctrl;

  localparam int NR = 4;

  // Input bits: {start_game, grade_it, grade_valid, grade_match, practice, abort}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_GI    = 6'b010000;
  localparam logic [5:0] I_GV    = 6'b001000;
  localparam logic [5:0] I_GM    = 6'b000100;
  localparam logic [5:0] I_PRAC  = 6'b000010;
  localparam logic [5:0] I_ABORT = 6'b000001;

  // Strobe bits: {c_clear, c_en, f_load, f_clear}
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_CLR  = 4'b1000;
  localparam logic [3:0] S_GUES = 4'b0110;
  localparam logic [3:0] S_FCLR = 4'b0001;

  // Registered flags: {busy, won, lost}
  localparam logic [2:0] R_IDLE = 3'b000;
  localparam logic [2:0] R_BUSY = 3'b100;
  localparam logic [2:0] R_WON  = 3'b010;
  localparam logic [2:0] R_LOST = 3'b001;

  typedef struct {
    string      tag;
    logic [3:0] strb;
    int         cnt;
    logic [2:0] flags;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  mastermind_round_ctrl_if #(.NUM_ROUNDS(NR)) bus ();

  mastermind_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {bus.start_game, bus.grade_it, bus.grade_valid,
     bus.grade_match, bus.practice, bus.abort} = in;
  endtask

  // One clock step: drive inputs, check Mealy strobes, then registered outputs.
  task automatic cyc(input string tag, input logic [5:0] in, input logic [3:0] strb,
                     input int cnt, input logic [2:0] flags);
    exp_t e;
    e.tag = tag; e.strb = strb; e.cnt = cnt; e.flags = flags;
    exp_q.push_back(e);
    drive(in);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".strb"}, 32'({bus.c_clear, bus.c_en, bus.f_load, bus.f_clear}), 32'(e.strb));
    @(posedge clock);
    #1;
    chk({e.tag, ".cnt"}, 32'(bus.round_cnt), 32'(e.cnt));
    chk({e.tag, ".flags"}, 32'({bus.busy, bus.won, bus.lost}), 32'(e.flags));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    drive(I_NONE);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state, idle inputs.
    cyc("reset_idle", I_NONE, S_NONE, 0, R_IDLE);
    cyc("abort_waiting", I_ABORT, S_NONE, 0, R_IDLE);

    // Start and first guess; grade_it ignored while grading.
    cyc("start", I_START, S_CLR, 0, R_BUSY);
    cyc("guess1", I_GI, S_GUES, 1, R_BUSY);
    cyc("gi_in_grading", I_GI, S_NONE, 1, R_BUSY);
    cyc("start_in_grading", I_START, S_NONE, 1, R_BUSY);
    cyc("miss1", I_GV, S_NONE, 1, R_BUSY);
    cyc("gv_in_guessing", I_GV | I_GM, S_NONE, 1, R_BUSY);
    cyc("guess2", I_GI, S_GUES, 2, R_BUSY);
    cyc("hit2", I_GV | I_GM, S_FCLR, 2, R_WON);
    for (int i = 0; i < 10; i++) cyc("won_hold", I_NONE, S_NONE, 2, R_WON);
    cyc("gi_in_done", I_GI, S_NONE, 2, R_WON);

    // Loss after NR misses in a normal game.
    cyc("start_loss", I_START, S_CLR, 0, R_BUSY);
    for (int i = 1; i <= NR; i++) begin
      cyc($sformatf("loss_guess%0d", i), I_GI, S_GUES, i, R_BUSY);
      if (i < NR) cyc($sformatf("loss_miss%0d", i), I_GV, S_NONE, i, R_BUSY);
      else        cyc("loss_final", I_GV, S_FCLR, NR, R_LOST);
    end
    cyc("gi_after_loss", I_GI, S_NONE, NR, R_LOST);
    cyc("gv_after_loss", I_GV | I_GM, S_NONE, NR, R_LOST);
    cyc("restart_after_loss", I_START, S_CLR, 0, R_BUSY);

    // grade_it beats start_game in GUESSING; abort beats a winning grade.
    cyc("gi_and_start", I_GI | I_START, S_GUES, 1, R_BUSY);
    cyc("abort_vs_win", I_ABORT | I_GV | I_GM, S_FCLR, 0, R_IDLE);
    cyc("gv_after_abort", I_GV | I_GM, S_NONE, 0, R_IDLE);

    // Practice: no loss at the limit, practice toggled mid-game, win on guess 7.
    cyc("start_prac", I_START | I_PRAC, S_CLR, 0, R_BUSY);
    for (int i = 1; i <= 6; i++) begin
      cyc($sformatf("prac_guess%0d", i), I_GI, S_GUES, i, R_BUSY);
      cyc($sformatf("prac_miss%0d", i), I_GV | ((i % 2 == 1) ? I_PRAC : I_NONE),
          S_NONE, i, R_BUSY);
    end
    cyc("prac_guess7", I_GI, S_GUES, 7, R_BUSY);
    cyc("prac_win7", I_GV | I_GM, S_FCLR, 7, R_WON);

    // Counter saturates at 2^ROUND_W-1 in a long practice game.
    cyc("start_sat", I_START | I_PRAC, S_CLR, 0, R_BUSY);
    for (int i = 1; i <= 8; i++) begin
      cyc($sformatf("sat_guess%0d", i), I_GI, S_GUES, (i > 7) ? 7 : i, R_BUSY);
      cyc($sformatf("sat_miss%0d", i), I_GV, S_NONE, (i > 7) ? 7 : i, R_BUSY);
    end
    cyc("sat_abort", I_ABORT, S_FCLR, 0, R_IDLE);

    // Practice resampled: a normal game after practice loses at NR.
    cyc("start_norm", I_START, S_CLR, 0, R_BUSY);
    for (int i = 1; i < NR; i++) begin
      cyc($sformatf("norm_guess%0d", i), I_GI, S_GUES, i, R_BUSY);
      cyc($sformatf("norm_miss%0d", i), I_GV, S_NONE, i, R_BUSY);
    end
    cyc("norm_guess_last", I_GI, S_GUES, NR, R_BUSY);
    cyc("norm_lose", I_GV, S_FCLR, NR, R_LOST);
    cyc("abort_done", I_ABORT, S_FCLR, 0, R_IDLE);

    // Reset in the middle of GRADING.
    cyc("start_rst", I_START, S_CLR, 0, R_BUSY);
    cyc("guess_rst", I_GI, S_GUES, 1, R_BUSY);
    drive(I_GV | I_GM);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midreset.cnt", 32'(bus.round_cnt), 32'd0);
    chk("midreset.flags", 32'({bus.busy, bus.won, bus.lost}), 32'(R_IDLE));
    cyc("gv_after_reset", I_GV | I_GM, S_NONE, 0, R_IDLE);
    cyc("start_after_reset", I_START, S_CLR, 0, R_BUSY);
    drive(I_NONE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mastermind_round_ctrl.md
Name: mastermind_round_ctrl

Overview:
- Parametrised successor to the three-state Mastermind game FSM.
- Sequences a whole game: start, guess entry, grading handshake with the grader, and win/loss decision.
- Owns the round counter internally and computes loss from a parametrised round limit.
- Adds a practice mode (no round limit), an abort path, and a DONE state that holds the result.
- Sits between the user-input debounce logic and the guess register/grader datapath.

Parameters:
- NUM_ROUNDS, 8, maximum guesses per normal game; must be >= 1 (elaboration-time assertion).
- ROUND_W, $clog2(NUM_ROUNDS+1), width of round_cnt; derived, not overridden.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- start_game  input  1  begin a new game.
- grade_it  input  1  current guess is entered; request grading.
- grade_valid  input  1  grader result valid this cycle (single-cycle pulse).
- grade_match  input  1  all pegs correct; qualified by grade_valid.
- practice  input  1  sampled on game start; 1 = unlimited rounds.
- abort  input  1  abandon the current game.
- c_clear  output  1  clear guess counter/display (Mealy strobe).
- c_en  output  1  enable guess counter (Mealy strobe).
- f_load  output  1  load guess register (Mealy strobe).
- f_clear  output  1  clear guess/feedback registers (Mealy strobe).
- round_cnt  output  ROUND_W  guesses submitted this game (registered).
- busy  output  1  state is GUESSING or GRADING.
- won  output  1  registered, sticky until next start, abort or reset.
- lost  output  1  registered, sticky until next start, abort or reset.

Behaviour:
- Reset: state WAITING; round_cnt=0; won=0; lost=0; practice_q=0. With inputs low, every strobe is 0. Reset overrides all inputs, including mid-game.
- Strobes are combinational from state and inputs, asserted in the same cycle as the triggering input. Registered outputs update on the following edge.
- State WAITING:
  - start_game -> GUESSING.
  - c_clear=1; round_cnt<=0; practice_q<=practice; won<=0; lost<=0.
- State GUESSING:
  - grade_it -> GRADING.
  - c_en=1; f_load=1; round_cnt<=round_cnt+1, saturating at 2^ROUND_W-1.
  - grade_valid is ignored.
- State GRADING:
  - grade_it and start_game are ignored.
  - On grade_valid:
    - grade_match=1 -> DONE; won<=1; f_clear=1.
    - else if practice_q=0 and round_cnt==NUM_ROUNDS -> DONE; lost<=1; f_clear=1.
    - else -> GUESSING; no strobe.
  - Without grade_valid the block waits indefinitely.
- State DONE:
  - won/lost held.
  - start_game -> GUESSING with the same actions as from WAITING (c_clear=1, counter cleared, results cleared, practice resampled).
  - grade_it and grade_valid are ignored.
- abort (GUESSING, GRADING or DONE):
  - -> WAITING; f_clear=1; won<=0; lost<=0; round_cnt<=0.
  - abort has priority over every other input in the same cycle.
  - abort in WAITING has no effect and produces no strobes.
- Simultaneous events:
  - grade_it together with start_game in GUESSING: grade_it wins; start_game is ignored.
  - grade_valid together with abort in GRADING: abort wins; won/lost stay 0.
- At most one of won/lost is ever 1.
- busy is combinational from state.
- Default branch: an illegal state encoding returns to WAITING with all strobes 0.

Decomposition:
- mastermind_pkg:
  - state enum round_state_t {WAITING, GUESSING, GRADING, DONE}, 2 bits.
  - Default NUM_ROUNDS localparam.
- One sub-module, round_counter: parametrised ROUND_W, synchronous clear, enable, saturating increment, registered count output.
- The FSM stays in mastermind_round_ctrl.

Test Plan:
- Reset: assert reset 2 cycles, then release with all inputs low -> state WAITING; round_cnt=0; won=lost=busy=0; all strobes 0.
- Start and first guess (NUM_ROUNDS=4): start_game 1 cycle -> c_clear=1 that cycle; next cycle busy=1, round_cnt=0. Then grade_it -> c_en=f_load=1 that cycle; round_cnt=1 and state GRADING next cycle.
- Win on guess 2: two guesses; first grade_valid with match=0, second with match=1 -> f_clear=1 on the second pulse; then won=1, lost=0, round_cnt=2, busy=0 (DONE). won stays 1 for 10 idle cycles.
- Loss (NUM_ROUNDS=4, practice=0): four misses -> after the 4th grade_valid, lost=1 and round_cnt=4. A further grade_it is ignored; start_game -> c_clear=1, then lost=0 and round_cnt=0.
- Practice mode: practice=1 at start, then six misses -> lost stays 0, round_cnt=6, state back in GUESSING each time. The 7th guess with match=1 -> won=1, round_cnt=7. Toggling practice mid-game has no effect.
- Abort and priority: abort together with grade_valid & grade_match in GRADING -> f_clear=1; state WAITING; won=lost=0; round_cnt=0. A grade_valid next cycle is ignored. Reset asserted mid-GRADING -> WAITING on the next edge.
